// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: memory-port tracker states and
// the stage-register control word.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    IReq,
    IDone
  } imem_state_t;

  typedef enum logic [1:0] {
    DIdle,
    DWait,
    DDone
  } dmem_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } stage_ctrl_t;

  localparam stage_ctrl_t CtrlHold   = stage_ctrl_t'(7'b0000000);
  localparam stage_ctrl_t CtrlNormal = stage_ctrl_t'(7'b1111100);
  localparam stage_ctrl_t CtrlFlush  = stage_ctrl_t'(7'b1111111);
  localparam stage_ctrl_t CtrlBubble = stage_ctrl_t'(7'b0011101);

  // The generic tracker runs the three-state FSM; the fetch port only
  // distinguishes "still requesting" from "instruction in hand".
  function automatic imem_state_t to_imem_state(input dmem_state_t s);
    return (s == DDone) ? IDone : IReq;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Instruction/data memory handshake bundle between the stall controller (master)
// and the caches plus EX/MEM control word (slave).
interface pipeline_stall_ctrl_if;

  logic                                   imem_read_o;
  logic                                   imem_resp_i;
  logic                                   dmem_read_i;
  logic                                   dmem_write_i;
  logic                                   dmem_resp_i;
  logic [pipeline_stall_ctrl_pkg::XLEN-1:0] dmem_rdata_i;
  logic                                   dmem_read_o;
  logic                                   dmem_write_o;
  logic [pipeline_stall_ctrl_pkg::XLEN-1:0] dmem_rdata_o;

  modport master (
    output imem_read_o, dmem_read_o, dmem_write_o, dmem_rdata_o,
    input  imem_resp_i, dmem_read_i, dmem_write_i, dmem_resp_i, dmem_rdata_i
  );

  modport slave (
    input  imem_read_o, dmem_read_o, dmem_write_o, dmem_rdata_o,
    output imem_resp_i, dmem_read_i, dmem_write_i, dmem_resp_i, dmem_rdata_i
  );

endinterface

// File: rtl/pipeline_stall_ctrl_mem_port_tracker.sv
// Outstanding-request tracker for one memory port: IDLE/WAIT/DONE FSM plus an
// optional register that holds response data until the pipeline advances.
module mem_port_tracker
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter bit HoldEn = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            resp_i,
  input  logic            advance_i,
  input  logic            keep_i,
  input  logic [XLEN-1:0] rdata_i,
  output dmem_state_t     state_o,
  output logic            ok_o,
  output logic [XLEN-1:0] rdata_o
);

  dmem_state_t     state_q, state_d;
  logic [XLEN-1:0] hold_q;
  logic            resp_acc;

  always_comb begin
    // A response with no outstanding request, or after one was already taken, is dropped.
    resp_acc = resp_i & req_i & (state_q != DDone) & ~rst;
    ok_o     = ~req_i | resp_acc | (state_q == DDone);
    state_o  = state_q;

    state_d = state_q;
    if (advance_i) begin
      state_d = keep_i ? DDone : DIdle;
    end else begin
      unique case (state_q)
        DIdle:   if (req_i) state_d = resp_i ? DDone : DWait;
        DWait:   if (resp_i) state_d = DDone;
        DDone:   state_d = DDone;
        default: state_d = DIdle;
      endcase
    end

    if (!HoldEn || rst) begin
      rdata_o = '0;
    end else begin
      rdata_o = resp_acc ? rdata_i : hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (HoldEn && resp_acc) hold_q <= rdata_i;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: advances the stage registers only when both memory
// ports are satisfied, inserts load-use bubbles, flushes on taken branches.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_stall_ctrl_if.master        mem_if,
  input  logic                         load_use_i,
  input  logic                         br_taken_i,
  output logic                         load_pc_o,
  output logic                         load_if_id_o,
  output logic                         load_id_ex_o,
  output logic                         load_ex_mem_o,
  output logic                         load_mem_wb_o,
  output logic                         flush_if_id_o,
  output logic                         flush_id_ex_o,
  output logic [CNT_WIDTH-1:0]         stall_cnt_o,
  output logic [CNT_WIDTH-1:0]         bubble_cnt_o
);

  dmem_state_t          imem_trk_state, dmem_state;
  imem_state_t          imem_state;
  logic                 imem_ok, dmem_ok, dmem_req, advance;
  logic                 keep_fetch, bubble_inc;
  logic [XLEN-1:0]      imem_rdata_nc;
  stage_ctrl_t          ctrl;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  assign dmem_req   = mem_if.dmem_read_i | mem_if.dmem_write_i;
  assign advance    = imem_ok & dmem_ok & ~rst;
  // A load-use bubble re-presents the same fetched instruction, so the fetch stays done.
  assign keep_fetch = load_use_i & ~br_taken_i;

  mem_port_tracker #(
    .HoldEn (1'b0)
  ) u_imem_trk (
    .clk       (clk),
    .rst       (rst),
    .req_i     (1'b1),
    .resp_i    (mem_if.imem_resp_i),
    .advance_i (advance),
    .keep_i    (keep_fetch),
    .rdata_i   ('0),
    .state_o   (imem_trk_state),
    .ok_o      (imem_ok),
    .rdata_o   (imem_rdata_nc)
  );

  mem_port_tracker #(
    .HoldEn (1'b1)
  ) u_dmem_trk (
    .clk       (clk),
    .rst       (rst),
    .req_i     (dmem_req),
    .resp_i    (mem_if.dmem_resp_i),
    .advance_i (advance),
    .keep_i    (1'b0),
    .rdata_i   (mem_if.dmem_rdata_i),
    .state_o   (dmem_state),
    .ok_o      (dmem_ok),
    .rdata_o   (mem_if.dmem_rdata_o)
  );

  assign imem_state          = to_imem_state(imem_trk_state);
  assign mem_if.imem_read_o  = ~rst & (imem_state == IReq);
  assign mem_if.dmem_read_o  = ~rst & mem_if.dmem_read_i & (dmem_state != DDone);
  assign mem_if.dmem_write_o = ~rst & mem_if.dmem_write_i & (dmem_state != DDone);

  always_comb begin
    ctrl       = CtrlHold;
    bubble_inc = 1'b0;
    if (advance) begin
      if (br_taken_i) begin
        ctrl = CtrlFlush;
      end else if (load_use_i) begin
        ctrl       = CtrlBubble;
        bubble_inc = 1'b1;
      end else begin
        ctrl = CtrlNormal;
      end
    end
  end

  assign load_pc_o     = ctrl.load_pc;
  assign load_if_id_o  = ctrl.load_if_id;
  assign load_id_ex_o  = ctrl.load_id_ex;
  assign load_ex_mem_o = ctrl.load_ex_mem;
  assign load_mem_wb_o = ctrl.load_mem_wb;
  assign flush_if_id_o = ctrl.flush_if_id;
  assign flush_id_ex_o = ctrl.flush_id_ex;

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!advance && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (bubble_inc && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; 4-bit counters make saturation reachable.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use, br_taken;
  logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic          flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  logic [6:0]    ctl;
  int            checks = 0;
  int            errors = 0;

  pipeline_stall_ctrl_if mif ();

  pipeline_stall_ctrl #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_if        (mif),
    .load_use_i    (load_use),
    .br_taken_i    (br_taken),
    .load_pc_o     (load_pc),
    .load_if_id_o  (load_if_id),
    .load_id_ex_o  (load_id_ex),
    .load_ex_mem_o (load_ex_mem),
    .load_mem_wb_o (load_mem_wb),
    .flush_if_id_o (flush_if_id),
    .flush_id_ex_o (flush_id_ex),
    .stall_cnt_o   (stall_cnt),
    .bubble_cnt_o  (bubble_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, flush_id_ex};

  localparam logic [6:0] HOLD   = 7'b0000000;
  localparam logic [6:0] NORMAL = 7'b1111100;
  localparam logic [6:0] BRANCH = 7'b1111111;
  localparam logic [6:0] BUBBLE = 7'b0011101;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_use = 1'b0;
    br_taken = 1'b0;
    mif.imem_resp_i  = 1'b0;
    mif.dmem_read_i  = 1'b0;
    mif.dmem_write_i = 1'b0;
    mif.dmem_resp_i  = 1'b0;
    mif.dmem_rdata_i = '0;

    // Reset state
    cyc();
    #1;
    chk("rst_imem_read", mif.imem_read_o, 0);
    chk("rst_ctl", ctl, HOLD);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_rdata", mif.dmem_rdata_o, 0);
    cyc();

    // First post-reset cycle with immediate fetch response
    rst = 1'b0;
    mif.imem_resp_i = 1'b1;
    #1;
    chk("t1_imem_read", mif.imem_read_o, 1);
    chk("t1_ctl", ctl, NORMAL);
    chk("t1_stall", stall_cnt, 0);
    cyc();

    // Load in MEM, dmem resp at cycle 3, imem resp at cycle 1
    mif.imem_resp_i = 1'b0;
    mif.dmem_read_i = 1'b1;
    #1;
    chk("t2_c0_ctl", ctl, HOLD);
    chk("t2_c0_dread", mif.dmem_read_o, 1);
    cyc();
    mif.imem_resp_i = 1'b1;
    #1;
    chk("t2_c1_ctl", ctl, HOLD);
    cyc();
    mif.imem_resp_i = 1'b0;
    #1;
    chk("t2_c2_imem_read", mif.imem_read_o, 0);
    chk("t2_c2_ctl", ctl, HOLD);
    cyc();
    mif.dmem_resp_i  = 1'b1;
    mif.dmem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("t2_c3_ctl", ctl, NORMAL);
    chk("t2_c3_rdata", mif.dmem_rdata_o, 32'hDEADBEEF);
    chk("t2_c3_stall", stall_cnt, 3);
    chk("t2_c3_imem_read", mif.imem_read_o, 0);
    cyc();

    // Early dmem resp held until a late imem resp; duplicate resp ignored
    mif.dmem_resp_i  = 1'b0;
    mif.dmem_rdata_i = '0;
    #1;
    chk("t3_c0_ctl", ctl, HOLD);
    cyc();
    mif.dmem_resp_i  = 1'b1;
    mif.dmem_rdata_i = 32'h12345678;
    #1;
    chk("t3_c1_rdata", mif.dmem_rdata_o, 32'h12345678);
    chk("t3_c1_dread", mif.dmem_read_o, 1);
    cyc();
    mif.dmem_rdata_i = 32'h55555555;
    #1;
    chk("t3_c2_dread", mif.dmem_read_o, 0);
    chk("t3_c2_dup_rdata", mif.dmem_rdata_o, 32'h12345678);
    cyc();
    mif.dmem_resp_i  = 1'b0;
    mif.dmem_rdata_i = '0;
    #1;
    chk("t3_c3_ctl", ctl, HOLD);
    cyc();
    mif.imem_resp_i = 1'b1;
    #1;
    chk("t3_c4_ctl", ctl, NORMAL);
    chk("t3_c4_rdata", mif.dmem_rdata_o, 32'h12345678);
    chk("t3_c4_stall", stall_cnt, 7);
    cyc();

    // Load-use bubble, then the held fetch advances without a new response
    mif.dmem_read_i = 1'b0;
    load_use = 1'b1;
    #1;
    chk("t4_ctl", ctl, BUBBLE);
    chk("t4_bubble_before", bubble_cnt, 0);
    cyc();
    mif.imem_resp_i = 1'b0;
    load_use = 1'b0;
    #1;
    chk("t4_next_ctl", ctl, NORMAL);
    chk("t4_next_imem_read", mif.imem_read_o, 0);
    chk("t4_next_bubble", bubble_cnt, 1);
    cyc();

    // Branch wins over load-use
    mif.imem_resp_i = 1'b1;
    br_taken = 1'b1;
    load_use = 1'b1;
    #1;
    chk("t5_ctl", ctl, BRANCH);
    cyc();
    mif.imem_resp_i = 1'b0;
    br_taken = 1'b0;
    load_use = 1'b0;
    #1;
    chk("t5_bubble", bubble_cnt, 1);
    chk("t5_imem_read", mif.imem_read_o, 1);
    chk("t5_ctl", ctl, HOLD);
    cyc();

    // Reset while a load is outstanding, then a stale response
    mif.dmem_read_i = 1'b1;
    #1;
    chk("t6_dread_pre", mif.dmem_read_o, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_dread", mif.dmem_read_o, 0);
    chk("t6_rst_ctl", ctl, HOLD);
    chk("t6_rst_imem_read", mif.imem_read_o, 0);
    cyc();
    rst = 1'b0;
    mif.dmem_read_i = 1'b0;
    #1;
    chk("t6_dread", mif.dmem_read_o, 0);
    chk("t6_ctl", ctl, HOLD);
    chk("t6_stall", stall_cnt, 0);
    chk("t6_bubble", bubble_cnt, 0);
    chk("t6_imem_read", mif.imem_read_o, 1);
    mif.dmem_resp_i  = 1'b1;
    mif.dmem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("t6_stale_rdata", mif.dmem_rdata_o, 0);
    cyc();
    mif.dmem_resp_i  = 1'b0;
    mif.dmem_rdata_i = '0;
    #1;
    chk("t6_hold_kept", mif.dmem_rdata_o, 0);
    chk("t6_stall_one", stall_cnt, 1);

    // Stall counter saturates without wrapping
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_stall", stall_cnt, 4'hF);
    cyc();
    chk("sat_stall_hold", stall_cnt, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
